// File: rtl/jpeg_du_pingpong_buf_pkg.sv
// Shared types and constants for the JPEG data-unit ping/pong buffer.
package jpeg_du_pingpong_buf_pkg;

   localparam int DU_SIZE_DEF = 64;

   // Colour channel numbering inside one bank
   typedef enum logic [1:0] {
      CH_Y = 2'd0,
      CH_U = 2'd1,
      CH_V = 2'd2
   } ch_e;

   // Number of committed banks not yet released
   typedef enum logic [1:0] {
      FC_EMPTY = 2'd0,
      FC_ONE   = 2'd1,
      FC_FULL  = 2'd2
   } fill_e;

   // Channel select width; a single channel still gets a one-bit field
   function automatic int ch_bits(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/jpeg_du_pingpong_buf_if.sv
// Writer/reader bus of the data-unit ping/pong buffer.
interface jpeg_du_pingpong_buf_if #(
   parameter int DATA_W = 8,
   parameter int CH_W   = 2,
   parameter int IDX_W  = 6
);
   logic              wr_ready;
   logic              wr_we;
   logic [CH_W-1:0]   wr_ch;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic              wr_commit;
   logic              rd_valid;
   logic [CH_W-1:0]   rd_ch;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_data;
   logic              rd_release;
   logic [1:0]        full_cnt;
   logic              err_ovf;
   logic              err_udf;

   // Client side: capture writer and DCT reader
   modport master (
      input  wr_ready, rd_valid, rd_data, full_cnt, err_ovf, err_udf,
      output wr_we, wr_ch, wr_idx, wr_data, wr_commit, rd_ch, rd_idx, rd_release
   );

   // Buffer side
   modport slave (
      output wr_ready, rd_valid, rd_data, full_cnt, err_ovf, err_udf,
      input  wr_we, wr_ch, wr_idx, wr_data, wr_commit, rd_ch, rd_idx, rd_release
   );
endinterface

// File: rtl/jpeg_du_pingpong_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register has a synchronous clear so the buffer output is
// defined right after reset; contents are never cleared.
module jpeg_sdp_ram #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];

   // Write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read port
   always_ff @(posedge clk) begin
      if (rst) rdata <= '0;
      else     rdata <= mem[raddr];
   end
endmodule

// File: rtl/jpeg_du_pingpong_buf.sv
// Ping/pong data-unit store between pixel capture and the DCT stage.
// The writer fills one bank while the reader drains the other; commit and
// release pulses hand banks back and forth, tracked by full_cnt.
module jpeg_du_pingpong_buf
   import jpeg_du_pingpong_buf_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int DU_SIZE = DU_SIZE_DEF,
   parameter int NUM_CH  = 3,
   parameter int OUT_REG = 0
) (
   input logic                    clk,
   input logic                    reset,
   jpeg_du_pingpong_buf_if.slave  bus
);
   localparam int CH_W  = ch_bits(NUM_CH);
   localparam int IDX_W = $clog2(DU_SIZE);
   localparam int AW    = 1 + CH_W + IDX_W;

   logic              wr_ptr;
   logic              rd_ptr;
   fill_e             full_q;
   logic              err_ovf_q;
   logic              err_udf_q;
   logic              wr_ready;
   logic              rd_valid;
   logic              commit_ok;
   logic              release_ok;
   logic              ch_ok;
   logic              ram_we;
   logic [AW-1:0]     waddr;
   logic [AW-1:0]     raddr;
   logic [DATA_W-1:0] rd_data_p1;

   assign wr_ready   = (full_q != FC_FULL);
   assign rd_valid   = (full_q != FC_EMPTY);
   assign commit_ok  = bus.wr_commit  & wr_ready;
   assign release_ok = bus.rd_release & rd_valid;
   // Channels beyond NUM_CH have no storage in the bank and are dropped
   assign ch_ok      = ({1'b0, bus.wr_ch} < (CH_W + 1)'(NUM_CH));
   assign ram_we     = bus.wr_we & wr_ready & ch_ok;
   assign waddr      = {wr_ptr, bus.wr_ch, bus.wr_idx};
   assign raddr      = {rd_ptr, bus.rd_ch, bus.rd_idx};

   assign bus.wr_ready = wr_ready;
   assign bus.rd_valid = rd_valid;
   assign bus.full_cnt = full_q;
   assign bus.err_ovf  = err_ovf_q;
   assign bus.err_udf  = err_udf_q;

   jpeg_sdp_ram #(
      .DW (DATA_W),
      .AW (AW)
   ) u_ram (
      .clk   (clk),
      .rst   (reset),
      .we    (ram_we),
      .waddr (waddr),
      .wdata (bus.wr_data),
      .raddr (raddr),
      .rdata (rd_data_p1)
   );

   // Bank pointers, fill count and sticky error flags
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         full_q    <= FC_EMPTY;
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         if (commit_ok)  wr_ptr <= ~wr_ptr;
         if (release_ok) rd_ptr <= ~rd_ptr;
         // A simultaneous commit and release leaves the count unchanged
         case ({commit_ok, release_ok})
            2'b10:   full_q <= (full_q == FC_EMPTY) ? FC_ONE : FC_FULL;
            2'b01:   full_q <= (full_q == FC_FULL)  ? FC_ONE : FC_EMPTY;
            default: full_q <= full_q;
         endcase
         if ((bus.wr_we | bus.wr_commit) & ~wr_ready) err_ovf_q <= 1'b1;
         if (bus.rd_release & ~rd_valid)              err_udf_q <= 1'b1;
      end
   end

   // ---- stage boundary: RAM read register -> optional output register ----
   if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] rd_data_p2;
      // Extra output register for timing; read latency becomes 2
      always_ff @(posedge clk) begin
         if (reset) rd_data_p2 <= '0;
         else       rd_data_p2 <= rd_data_p1;
      end
      assign bus.rd_data = rd_data_p2;
   end else begin : g_noreg
      assign bus.rd_data = rd_data_p1;
   end
endmodule

// File: tb/tb_jpeg_du_pingpong_buf.sv
// Directed bench for the data-unit ping/pong buffer: default configuration
// plus a single-channel 12-bit instance with the output register enabled.
module tb_jpeg_du_pingpong_buf;
   import jpeg_du_pingpong_buf_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   jpeg_du_pingpong_buf_if #(.DATA_W(8),  .CH_W(2), .IDX_W(6)) b0 ();
   jpeg_du_pingpong_buf_if #(.DATA_W(12), .CH_W(1), .IDX_W(6)) b1 ();

   jpeg_du_pingpong_buf #(.DATA_W(8), .DU_SIZE(64), .NUM_CH(3), .OUT_REG(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (b0.slave)
   );

   jpeg_du_pingpong_buf #(.DATA_W(12), .DU_SIZE(64), .NUM_CH(1), .OUT_REG(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs and outputs are handled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      b0.wr_we = 1'b0; b0.wr_commit = 1'b0; b0.rd_release = 1'b0;
   endtask

   // Fill all three channels of the current write bank with one value
   task automatic fill0(input logic [7:0] val);
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 64; i++) begin
            b0.wr_we = 1'b1; b0.wr_ch = 2'(c); b0.wr_idx = 6'(i); b0.wr_data = val;
            tick();
         end
      end
      b0.wr_we = 1'b0;
   endtask

   task automatic commit0();
      b0.wr_commit = 1'b1; tick(); b0.wr_commit = 1'b0;
   endtask

   task automatic release0();
      b0.rd_release = 1'b1; tick(); b0.rd_release = 1'b0;
   endtask

   task automatic read0(input logic [1:0] ch, input logic [5:0] idx, output logic [7:0] q);
      b0.rd_ch = ch; b0.rd_idx = idx; tick(); q = b0.rd_data;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q;
      b0.wr_we = 0; b0.wr_ch = 0; b0.wr_idx = 0; b0.wr_data = 0; b0.wr_commit = 0;
      b0.rd_ch = 0; b0.rd_idx = 0; b0.rd_release = 0;
      b1.wr_we = 0; b1.wr_ch = 0; b1.wr_idx = 0; b1.wr_data = 0; b1.wr_commit = 0;
      b1.rd_ch = 0; b1.rd_idx = 0; b1.rd_release = 0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      check("rst_wr_ready", 32'(b0.wr_ready), 32'd1);
      check("rst_rd_valid", 32'(b0.rd_valid), 32'd0);
      check("rst_full_cnt", 32'(b0.full_cnt), 32'd0);
      check("rst_rd_data",  32'(b0.rd_data),  32'd0);
      check("rst_errs",     32'({b0.err_ovf, b0.err_udf}), 32'd0);

      // 1: Y[i]=i, commit, read Y[5]
      for (int i = 0; i < 64; i++) begin
         b0.wr_we = 1'b1; b0.wr_ch = CH_Y; b0.wr_idx = 6'(i); b0.wr_data = 8'(i);
         tick();
      end
      b0.wr_we = 1'b0;
      check("t1_rd_valid_pre", 32'(b0.rd_valid), 32'd0);
      commit0();
      check("t1_rd_valid", 32'(b0.rd_valid), 32'd1);
      check("t1_full_cnt", 32'(b0.full_cnt), 32'd1);
      read0(CH_Y, 6'd5, q);
      check("t1_y5", 32'(q), 32'd5);
      read0(CH_Y, 6'd63, q);
      check("t1_y63", 32'(q), 32'd63);
      release0();
      check("t1_full_rel", 32'(b0.full_cnt), 32'd0);

      // 2: two banks A=11, B=22, overflow write, release
      fill0(8'h11); commit0();
      fill0(8'h22); commit0();
      check("t2_full_cnt", 32'(b0.full_cnt), 32'd2);
      check("t2_wr_ready", 32'(b0.wr_ready), 32'd0);
      check("t2_ovf_pre",  32'(b0.err_ovf),  32'd0);
      b0.wr_we = 1'b1; b0.wr_ch = CH_Y; b0.wr_idx = 6'd3; b0.wr_data = 8'h99;
      tick(); idle0();
      check("t2_ovf",      32'(b0.err_ovf),  32'd1);
      check("t2_full_ovf", 32'(b0.full_cnt), 32'd2);
      read0(CH_Y, 6'd3, q);
      check("t2_bank_a", 32'(q), 32'h11);
      release0();
      check("t2_full_rel", 32'(b0.full_cnt), 32'd1);
      read0(CH_Y, 6'd3, q);
      check("t2_b_y3", 32'(q), 32'h22);
      read0(CH_V, 6'd63, q);
      check("t2_b_v63", 32'(q), 32'h22);

      // 3: commit+release in one cycle at full_cnt=1; same-cycle write/read use old banks
      b0.wr_we = 1'b1; b0.wr_ch = CH_Y; b0.wr_idx = 6'd7; b0.wr_data = 8'h33;
      tick();
      b0.wr_ch = CH_U; b0.wr_idx = 6'd9; b0.wr_data = 8'h44;
      b0.wr_commit = 1'b1; b0.rd_release = 1'b1; b0.rd_ch = CH_Y; b0.rd_idx = 6'd3;
      tick(); idle0();
      check("t3_old_rd_bank", 32'(b0.rd_data),  32'h22);
      check("t3_full_cnt",    32'(b0.full_cnt), 32'd1);
      check("t3_wr_ready",    32'(b0.wr_ready), 32'd1);
      read0(CH_Y, 6'd7, q);
      check("t3_new_y7", 32'(q), 32'h33);
      read0(CH_U, 6'd9, q);
      check("t3_commit_wr", 32'(q), 32'h44);
      read0(CH_Y, 6'd3, q);
      check("t3_new_y3", 32'(q), 32'h11);

      // 4: underflow
      release0();
      check("t4_full_0",   32'(b0.full_cnt), 32'd0);
      check("t4_udf_pre",  32'(b0.err_udf),  32'd0);
      release0();
      check("t4_udf",      32'(b0.err_udf),  32'd1);
      check("t4_full_stay",32'(b0.full_cnt), 32'd0);

      // 5: reset with both banks full
      commit0(); commit0();
      check("t5_full_2", 32'(b0.full_cnt), 32'd2);
      reset = 1'b1; tick(); reset = 1'b0;
      check("t5_full_cnt", 32'(b0.full_cnt), 32'd0);
      check("t5_wr_ready", 32'(b0.wr_ready), 32'd1);
      check("t5_rd_valid", 32'(b0.rd_valid), 32'd0);
      check("t5_rd_data",  32'(b0.rd_data),  32'd0);
      check("t5_errs",     32'({b0.err_ovf, b0.err_udf}), 32'd0);

      // 6: OUT_REG=1, NUM_CH=1, DATA_W=12
      check("t6_rst_rd_data", 32'(b1.rd_data), 32'd0);
      b1.wr_we = 1'b1; b1.wr_ch = 1'b0; b1.wr_idx = 6'd0;  b1.wr_data = 12'h123; tick();
      b1.wr_idx = 6'd63; b1.wr_data = 12'hABC; tick();
      b1.wr_we = 1'b0; b1.wr_commit = 1'b1; tick();
      b1.wr_commit = 1'b0;
      check("t6_rd_valid", 32'(b1.rd_valid), 32'd1);
      tick();
      check("t6_idx0", 32'(b1.rd_data), 32'h123);
      b1.rd_idx = 6'd63;
      tick();
      check("t6_lat1", 32'(b1.rd_data), 32'h123);
      tick();
      check("t6_lat2", 32'(b1.rd_data), 32'hABC);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
